// File: rtl/mrv32_mc_ctrl.sv
// mrv32_mc_ctrl - multi-cycle control FSM for the MRV32 RV32I core.
//
// Sequences FETCH/DECODE/EXEC/MEM/WB over a single shared memory port and
// drives every datapath strobe and mux select. It holds no datapath state;
// the only instruction bits it decodes are the opcode field instr_i[6:0].
//
// Optional build macro:
//   MRV32_MC_TRAP_EN  when defined, an unsupported opcode parks the FSM in
//                     TRAP until reset. When undefined, the instruction is
//                     dropped and fetching continues (illegal_o still sets).
//
// Parameter:
//   MEM_TIMEOUT_CYC   waiting cycles (mem_req_o high, no mem_ready_i) before
//                     the access is abandoned; 0 disables the timeout.
//
// Ports:
//   clk, rst_n        core clock (rising edge), async active-low reset
//   instr_i           IR contents, valid from DECODE onward
//   mem_ready_i       memory accepts/completes the current access
//   branch_taken_i    ALU compare result, used in EXEC for branches
//   mem_req_o/mem_we_o/mem_addr_sel_o   memory request, store, 0=PC 1=ALU
//   ir_we_o, pc_we_o, pc_sel_o          IR/OLD_PC load, PC write, 0=+4 1=ALU 2=ALU&~1
//   imm_sel_o                            IMM_I=0 S=1 B=2 U=3 J=4
//   alu_a_sel_o, alu_b_sel_o             0=rs1/1=OLD_PC, 0=rs2/1=imm
//   rf_we_o, wb_sel_o                    regfile write, 0=ALU 1=mem 2=OLD_PC+4
//   mem_err_o, illegal_o                 sticky timeout / illegal opcode flags
//   state_o                              current state (debug)
//
// state  | meaning
// IDLE   | out of reset, one cycle before the first fetch
// FETCH  | read instruction at PC; load IR, advance PC on mem_ready
// DECODE | register-file read, opcode legality check
// EXEC   | ALU operation, branch/jump PC update
// MEM    | load/store data access at ALU address
// WB     | single-cycle register-file write
// TRAP   | illegal opcode with trap enabled; only reset leaves

module mrv32_mc_ctrl #(
    parameter int unsigned MEM_TIMEOUT_CYC = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr_i,
    input  logic        mem_ready_i,
    input  logic        branch_taken_i,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic        mem_addr_sel_o,
    output logic        ir_we_o,
    output logic        pc_we_o,
    output logic [1:0]  pc_sel_o,
    output logic [2:0]  imm_sel_o,
    output logic        alu_a_sel_o,
    output logic        alu_b_sel_o,
    output logic        rf_we_o,
    output logic [1:0]  wb_sel_o,
    output logic        mem_err_o,
    output logic        illegal_o,
    output logic [2:0]  state_o
);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_MISC   = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_U = 3'd3;
    localparam logic [2:0] IMM_J = 3'd4;

    localparam bit TO_EN = (MEM_TIMEOUT_CYC != 0);
    localparam int CNT_W = (MEM_TIMEOUT_CYC > 1) ? $clog2(MEM_TIMEOUT_CYC) : 1;
    // Abort happens on the waiting cycle in which the count has already
    // reached TIMEOUT-1, i.e. after exactly MEM_TIMEOUT_CYC waiting cycles.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_TRAP   = 3'd6
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mem_err_q, mem_err_d;
    logic             illegal_q, illegal_d;

    logic [6:0] opcode;
    logic       is_load, is_store, is_jump, legal, timeout_hit;
    logic       unused_instr;

    assign opcode       = instr_i[6:0];
    assign unused_instr = ^instr_i[31:7];
    assign is_load      = (opcode == OP_LOAD);
    assign is_store     = (opcode == OP_STORE);
    assign is_jump      = (opcode == OP_JAL) || (opcode == OP_JALR);
    assign legal        = (opcode == OP_LUI)  || (opcode == OP_AUIPC) || (opcode == OP_JAL)
                       || (opcode == OP_JALR) || (opcode == OP_BRANCH) || is_load || is_store
                       || (opcode == OP_IMM)  || (opcode == OP_OP)    || (opcode == OP_MISC)
                       || (opcode == OP_SYSTEM);
    assign timeout_hit  = TO_EN && (cnt_q == CNT_LAST);

    always_comb begin
        case (opcode)
            OP_LUI, OP_AUIPC: imm_sel_o = IMM_U;
            OP_JAL:           imm_sel_o = IMM_J;
            OP_BRANCH:        imm_sel_o = IMM_B;
            OP_STORE:         imm_sel_o = IMM_S;
            default:          imm_sel_o = IMM_I;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            mem_err_q <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mem_err_q <= mem_err_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = '0;
        mem_err_d      = mem_err_q;
        illegal_d      = illegal_q;
        mem_req_o      = 1'b0;
        mem_we_o       = 1'b0;
        mem_addr_sel_o = 1'b0;
        ir_we_o        = 1'b0;
        pc_we_o        = 1'b0;
        pc_sel_o       = 2'd0;
        alu_a_sel_o    = 1'b0;
        alu_b_sel_o    = 1'b0;
        rf_we_o        = 1'b0;
        wb_sel_o       = 2'd0;

        case (state_q)
            S_IDLE: state_d = S_FETCH;

            S_FETCH: begin
                mem_req_o = 1'b1;
                if (mem_ready_i) begin
                    ir_we_o = 1'b1;
                    pc_we_o = 1'b1;
                    state_d = S_DECODE;
                end else if (timeout_hit) begin
                    mem_err_d = 1'b1;
                    state_d   = S_FETCH;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_DECODE: begin
                if (!legal) begin
                    illegal_d = 1'b1;
`ifdef MRV32_MC_TRAP_EN
                    state_d   = S_TRAP;
`else
                    state_d   = S_FETCH;
`endif
                end else begin
                    state_d = S_EXEC;
                end
            end

            S_EXEC: begin
                case (opcode)
                    OP_BRANCH: begin
                        pc_we_o     = branch_taken_i;
                        pc_sel_o    = 2'd1;
                        alu_a_sel_o = 1'b1;
                        alu_b_sel_o = 1'b1;
                        state_d     = S_FETCH;
                    end
                    OP_JAL: begin
                        pc_we_o     = 1'b1;
                        pc_sel_o    = 2'd1;
                        alu_a_sel_o = 1'b1;
                        alu_b_sel_o = 1'b1;
                        state_d     = S_WB;
                    end
                    OP_JALR: begin
                        pc_we_o     = 1'b1;
                        pc_sel_o    = 2'd2;
                        alu_b_sel_o = 1'b1;
                        state_d     = S_WB;
                    end
                    OP_LOAD, OP_STORE: begin
                        alu_b_sel_o = 1'b1;
                        state_d     = S_MEM;
                    end
                    OP_OP: state_d = S_WB;
                    OP_IMM, OP_LUI: begin
                        alu_b_sel_o = 1'b1;
                        state_d     = S_WB;
                    end
                    OP_AUIPC: begin
                        alu_a_sel_o = 1'b1;
                        alu_b_sel_o = 1'b1;
                        state_d     = S_WB;
                    end
                    default: state_d = S_FETCH;
                endcase
            end

            S_MEM: begin
                mem_req_o      = 1'b1;
                mem_addr_sel_o = 1'b1;
                mem_we_o       = is_store;
                alu_b_sel_o    = 1'b1;
                if (mem_ready_i) begin
                    state_d = is_load ? S_WB : S_FETCH;
                end else if (timeout_hit) begin
                    // PC was advanced in FETCH; the instruction is simply dropped.
                    mem_err_d = 1'b1;
                    state_d   = S_FETCH;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_WB: begin
                rf_we_o  = 1'b1;
                wb_sel_o = is_load ? 2'd1 : (is_jump ? 2'd2 : 2'd0);
                state_d  = S_FETCH;
            end

            S_TRAP: state_d = S_TRAP;

            default: state_d = S_IDLE;
        endcase
    end

    assign mem_err_o = mem_err_q;
    assign illegal_o = illegal_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_mrv32_mc_ctrl.sv
module tb_mrv32_mc_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] instr_i = '0;
    logic        mem_ready_i = 1'b0;
    logic        branch_taken_i = 1'b0;
    logic        mem_req_o, mem_we_o, mem_addr_sel_o, ir_we_o, pc_we_o;
    logic [1:0]  pc_sel_o, wb_sel_o;
    logic [2:0]  imm_sel_o, state_o;
    logic        alu_a_sel_o, alu_b_sel_o, rf_we_o, mem_err_o, illegal_o;

    mrv32_mc_ctrl #(.MEM_TIMEOUT_CYC(4)) dut (
        .clk(clk), .rst_n(rst_n), .instr_i(instr_i), .mem_ready_i(mem_ready_i),
        .branch_taken_i(branch_taken_i), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
        .mem_addr_sel_o(mem_addr_sel_o), .ir_we_o(ir_we_o), .pc_we_o(pc_we_o),
        .pc_sel_o(pc_sel_o), .imm_sel_o(imm_sel_o), .alu_a_sel_o(alu_a_sel_o),
        .alu_b_sel_o(alu_b_sel_o), .rf_we_o(rf_we_o), .wb_sel_o(wb_sel_o),
        .mem_err_o(mem_err_o), .illegal_o(illegal_o), .state_o(state_o)
    );

    always #5 clk = ~clk;

    localparam logic [6:0] LUI = 7'h37, AUIPC = 7'h17, JAL = 7'h6F, JALR = 7'h67;
    localparam logic [6:0] BR = 7'h63, LD = 7'h03, ST = 7'h23, OPI = 7'h13, OPR = 7'h33;
    localparam logic [6:0] MISC = 7'h0F, SYS = 7'h73;

    logic [6:0] ops [11] = '{LUI, AUIPC, JAL, JALR, BR, LD, ST, OPI, OPR, MISC, SYS};
    logic [6:0] bad_ops [4] = '{7'h7F, 7'h00, 7'h0B, 7'h5B};

    typedef struct packed {
        logic [7:0] gap;
        logic [7:0] off;
        logic [2:0] st;
        logic       ir_we;
        logic       pc_we;
        logic [1:0] pc_sel;
        logic       rf_we;
        logic [1:0] wb_sel;
        logic       mem_req;
        logic       mem_hs;
        logic       mem_we;
        logic       addr_sel;
        logic [2:0] imm;
        logic       alu_a;
        logic       alu_b;
        logic       mem_err;
        logic       illegal;
    } ev_t;

    ev_t exp_q[$];
    ev_t msk_q[$];
    int  n_cmp = 0;
    int  n_err = 0;
    bit  mon_en = 1'b0;
    int  prev_post = 255;
    bit  ill_exp = 1'b0;

    function automatic logic [2:0] imm_of(input logic [6:0] op);
        if (op == LUI || op == AUIPC) return 3'd3;
        if (op == JAL) return 3'd4;
        if (op == BR)  return 3'd2;
        if (op == ST)  return 3'd1;
        return 3'd0;
    endfunction

    function automatic bit is_legal(input logic [6:0] op);
        foreach (ops[i]) if (ops[i] == op) return 1'b1;
        return 1'b0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic push(input ev_t e, input ev_t m);
        exp_q.push_back(e);
        msk_q.push_back(m);
    endtask

    // Reference model: turns one instruction into the strobe events the
    // controller must present, using the documented per-class latencies.
    task automatic model_instr(input logic [6:0] op, input int wf, input int wm, input bit taken);
        ev_t e, m;
        logic [2:0] imm;
        imm = imm_of(op);

        e = '0; m = '1;
        e.gap = (prev_post == 255) ? 8'hFF : 8'(prev_post + wf);
        e.st = 3'd1; e.ir_we = 1; e.pc_we = 1; e.pc_sel = 0; e.mem_req = 1; e.mem_hs = 1;
        e.imm = imm; e.illegal = ill_exp;
        m.wb_sel = 0; m.alu_a = 0; m.alu_b = 0;
        push(e, m);

        if (!is_legal(op)) begin
            ill_exp = 1'b1;
            prev_post = 2;
            return;
        end

        e = '0; m = '1;
        e.off = 8'd2; e.st = 3'd3; e.imm = imm; e.illegal = ill_exp;
        m.wb_sel = 0; m.mem_we = 0; m.addr_sel = 0; m.pc_sel = 0;
        case (op)
            BR:   begin e.pc_we = taken; e.pc_sel = 1; m.pc_sel = '1; e.alu_a = 1; e.alu_b = 1; end
            JAL:  begin e.pc_we = 1; e.pc_sel = 1; m.pc_sel = '1; e.alu_a = 1; e.alu_b = 1; end
            JALR: begin e.pc_we = 1; e.pc_sel = 2; m.pc_sel = '1; e.alu_b = 1; end
            LD, ST, OPI: e.alu_b = 1;
            LUI:  begin e.alu_b = 1; m.alu_a = 0; end
            AUIPC: begin e.alu_a = 1; e.alu_b = 1; end
            OPR:  ;
            default: begin m.alu_a = 0; m.alu_b = 0; end
        endcase
        push(e, m);

        if (op == LD || op == ST) begin
            e = '0; m = '1;
            e.off = 8'(3 + wm); e.st = 3'd4; e.mem_req = 1; e.mem_hs = 1;
            e.mem_we = (op == ST); e.addr_sel = 1; e.imm = imm; e.illegal = ill_exp;
            m.pc_sel = 0; m.wb_sel = 0; m.alu_a = 0; m.alu_b = 0;
            push(e, m);
        end

        if (op == LD || op == JAL || op == JALR || op == OPI || op == OPR
                || op == LUI || op == AUIPC) begin
            e = '0; m = '1;
            e.off = (op == LD) ? 8'(4 + wm) : 8'd3; e.st = 3'd5; e.rf_we = 1;
            e.wb_sel = (op == LD) ? 2'd1 : ((op == JAL || op == JALR) ? 2'd2 : 2'd0);
            e.imm = imm; e.illegal = ill_exp;
            m.pc_sel = 0; m.mem_we = 0; m.addr_sel = 0; m.alu_a = 0; m.alu_b = 0;
            push(e, m);
        end

        if (op == LD)       prev_post = 5 + wm;
        else if (op == ST)  prev_post = 4 + wm;
        else if (op == BR || op == MISC || op == SYS) prev_post = 3;
        else                prev_post = 4;
    endtask

    // Monitor: every cycle with a strobe, a memory handshake or EXEC is an event.
    initial begin
        logic [7:0] off_c, gap_c;
        ev_t a, e, m;
        off_c = 0; gap_c = 8'hFF;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                off_c = 0; gap_c = 8'hFF;
            end else begin
                if (mon_en && (ir_we_o || pc_we_o || rf_we_o || (mem_req_o && mem_ready_i)
                               || state_o == 3'd3)) begin
                    a = '0;
                    a.gap = ir_we_o ? gap_c : 8'd0;
                    a.off = ir_we_o ? 8'd0 : off_c;
                    a.st = state_o; a.ir_we = ir_we_o; a.pc_we = pc_we_o; a.pc_sel = pc_sel_o;
                    a.rf_we = rf_we_o; a.wb_sel = wb_sel_o; a.mem_req = mem_req_o;
                    a.mem_hs = mem_req_o && mem_ready_i; a.mem_we = mem_we_o;
                    a.addr_sel = mem_addr_sel_o; a.imm = imm_sel_o; a.alu_a = alu_a_sel_o;
                    a.alu_b = alu_b_sel_o; a.mem_err = mem_err_o; a.illegal = illegal_o;
                    n_cmp++;
                    if (exp_q.size() == 0) begin
                        n_err++;
                        $display("FAIL event_unexpected: got %h expected none", a);
                    end else begin
                        e = exp_q.pop_front();
                        m = msk_q.pop_front();
                        if (((a ^ e) & m) != '0) begin
                            n_err++;
                            $display("FAIL event: got %h expected %h (mask %h) at %0t", a, e, m, $time);
                        end
                    end
                end
                if (ir_we_o) begin
                    off_c = 1; gap_c = 1;
                end else begin
                    off_c = off_c + 1;
                    if (gap_c != 8'hFF) gap_c = gap_c + 1;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req();
        int n = 0;
        while (!mem_req_o && n < 50) begin
            step();
            n++;
        end
        if (!mem_req_o) begin
            n_cmp++;
            n_err++;
            $display("FAIL wait_req: got mem_req 0 expected 1 within 50 cycles");
        end
    endtask

    // Hold mem_ready low for w cycles of an outstanding request, then accept.
    task automatic serve(input int w);
        int left = w;
        mem_ready_i = (left == 0);
        for (int n = 0; n < 20; n++) begin
            step();
            if (mem_ready_i) begin
                mem_ready_i = 1'b0;
                return;
            end
            left--;
            mem_ready_i = (left == 0);
        end
        mem_ready_i = 1'b0;
    endtask

    task automatic run_instr(input logic [6:0] op, input int wf, input int wm, input bit taken);
        logic [31:0] r;
        model_instr(op, wf, wm, taken);
        wait_req();
        r = $urandom();
        instr_i = {r[31:7], op};
        branch_taken_i = taken;
        serve(wf);
        if (op == LD || op == ST) begin
            wait_req();
            serve(wm);
        end
    endtask

    task automatic do_reset();
        mon_en = 1'b0;
        mem_ready_i = 1'b0;
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        int k, nsel;
        logic [6:0] op;

        // Reset state and IDLE -> FETCH after one cycle.
        step();
        chk("rst_state", 32'(state_o), 32'd0);
        chk("rst_strobes", {27'd0, mem_req_o, mem_we_o, ir_we_o, pc_we_o, rf_we_o}, 32'd0);
        chk("rst_flags", {30'd0, mem_err_o, illegal_o}, 32'd0);
        mon_en = 1'b1;
        rst_n = 1'b1;
        chk("idle_after_rst", 32'(state_o), 32'd0);
        step();
        chk("fetch_after_idle", 32'(state_o), 32'd1);

        // Directed cases from the block description, then randomized traffic.
        run_instr(OPI, 0, 0, 0);
        run_instr(LD, 0, 3, 0);
        run_instr(BR, 0, 0, 0);
        run_instr(BR, 0, 0, 1);
        run_instr(JALR, 0, 0, 0);
        run_instr(ST, 3, 0, 0);
`ifdef MRV32_MC_TRAP_EN
        nsel = 11;
`else
        nsel = 13;
`endif
        for (int i = 0; i < 160; i++) begin
            k = int'($urandom_range(0, nsel - 1));
            op = (k < 11) ? ops[k] : bad_ops[$urandom_range(0, 3)];
            run_instr(op, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                      1'($urandom_range(0, 1)));
        end
        repeat (6) step();
        mon_en = 1'b0;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        // Illegal opcode 7'h7F.
        do_reset();
        wait_req();
        instr_i = 32'h0000007F;
        mem_ready_i = 1'b1;
        step();
        mem_ready_i = 1'b0;
        chk("ill_decode", 32'(state_o), 32'd2);
        step();
        chk("ill_flag", 32'(illegal_o), 32'd1);
`ifdef MRV32_MC_TRAP_EN
        chk("ill_trap", 32'(state_o), 32'd6);
        repeat (5) step();
        chk("trap_held", 32'(state_o), 32'd6);
        chk("trap_strobes", {27'd0, mem_req_o, mem_we_o, ir_we_o, pc_we_o, rf_we_o}, 32'd0);
`else
        chk("ill_refetch", 32'(state_o), 32'd1);
        chk("ill_refetch_req", 32'(mem_req_o), 32'd1);
`endif

        // FETCH timeout: 3 waiting cycles tolerated, the 4th aborts.
        do_reset();
        wait_req();
        repeat (3) step();
        chk("fetch_to_before", 32'(mem_err_o), 32'd0);
        chk("fetch_to_before_st", 32'(state_o), 32'd1);
        step();
        chk("fetch_to_err", 32'(mem_err_o), 32'd1);
        chk("fetch_to_state", 32'(state_o), 32'd1);
        chk("fetch_to_req", 32'(mem_req_o), 32'd1);
        mem_ready_i = 1'b1;
        #1;
        chk("fetch_after_to_irwe", 32'(ir_we_o), 32'd1);
        step();
        mem_ready_i = 1'b0;

        // MEM timeout on a load: dropped, no register write.
        do_reset();
        wait_req();
        instr_i = {25'h0, LD};
        mem_ready_i = 1'b1;
        step();
        mem_ready_i = 1'b0;
        wait_req();
        chk("mem_addr_sel", 32'(mem_addr_sel_o), 32'd1);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("mem_to_no_rfwe", 32'(rf_we_o), 32'd0);
        end
        chk("mem_to_err", 32'(mem_err_o), 32'd1);
        chk("mem_to_state", 32'(state_o), 32'd1);
        chk("mem_to_addr", 32'(mem_addr_sel_o), 32'd0);

        // Async reset while a store waits in MEM.
        do_reset();
        wait_req();
        instr_i = {25'h0, ST};
        mem_ready_i = 1'b1;
        step();
        mem_ready_i = 1'b0;
        wait_req();
        chk("st_in_mem", 32'(state_o), 32'd4);
        chk("st_mem_we", 32'(mem_we_o), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_state", 32'(state_o), 32'd0);
        chk("rst_mid_strobes", {27'd0, mem_req_o, mem_we_o, ir_we_o, pc_we_o, rf_we_o}, 32'd0);
        step();
        rst_n = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
